// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: groups the fetch, load/store and memory-side signals
// of the memory port arbiter.
//   slave  modport: arbiter view (takes requests and mem_rdata, drives grants,
//                   read returns and the memory address/write pins)
//   master modport: pipeline/memory view (the opposite directions)
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

interface mem_port_arbiter_if #(
    parameter int AW = `ISIZE,
    parameter int DW = `DSIZE
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wen, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wen, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (I) and load/store (D). One grant per cycle; D wins contention until fetch
// has been denied STARVE_MAX consecutive cycles. Read data returns one cycle
// after the grant, qualified by the owner's rvalid.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mem_port_arbiter_if.slave (requests, grants, read returns, memory pins)
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module mem_port_arbiter #(
    parameter int AW         = `ISIZE,
    parameter int DW         = `DSIZE,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_t        owner, owner_next;
    logic [3:0]    starve_cnt, starve_next;
    logic          grant_i, grant_d;
    logic [AW-1:0] addr_sel;
    logic          wen_sel;
    logic [DW-1:0] wdata_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        owner_next  = OWN_NONE;
        starve_next = '0;
        addr_sel    = '0;
        wen_sel     = 1'b0;
        wdata_sel   = '0;

        // Nothing is granted while in reset, which also keeps mem_wen low.
        if (!rst) begin
            if (bus.i_req && (!bus.d_req || starve_cnt >= STARVE_LIM))
                grant_i = 1'b1;
            else if (bus.d_req)
                grant_d = 1'b1;
        end

        if (grant_i) begin
            owner_next = OWN_I;
            addr_sel   = bus.i_addr;
        end else if (grant_d) begin
            owner_next = bus.d_we ? OWN_NONE : OWN_D;
            addr_sel   = bus.d_addr;
            wen_sel    = bus.d_we;
            wdata_sel  = bus.d_wdata;
            // Fetch only loses when D wins with the count below the limit,
            // so the increment can never pass STARVE_MAX.
            if (bus.i_req)
                starve_next = starve_cnt + 4'd1;
        end
    end

    assign bus.i_gnt     = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wen   = wen_sel;
    assign bus.mem_wdata = wdata_sel;

    assign bus.i_rvalid  = (owner == OWN_I);
    assign bus.d_rvalid  = (owner == OWN_D);
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven directed vectors, a reset-mid-read
// sequence, then randomized traffic checked against a reference model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(.AW(16), .DW(16), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port memory with registered read address.
    logic [15:0] mem [256];
    logic [15:0] addr_q;
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) mem[a] <= 16'h1000 + 16'(a);
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        addr_q <= bus.mem_addr;
    end
    assign bus.mem_rdata = mem[addr_q[7:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic        eig;
        logic        edg;
        logic        ewen;
        logic [15:0] eaddr;
        logic        eirv;
        logic        edrv;
        logic [15:0] erdata;
    } vec_t;

    function automatic vec_t v(logic ir, logic [15:0] ia, logic dr, logic dw,
                               logic [15:0] da, logic [15:0] dd, logic eig,
                               logic edg, logic ewen, logic [15:0] ea,
                               logic eirv, logic edrv, logic [15:0] erd);
        vec_t r;
        r.ireq = ir; r.iaddr = ia; r.dreq = dr; r.dwe = dw; r.daddr = da;
        r.dwdata = dd; r.eig = eig; r.edg = edg; r.ewen = ewen; r.eaddr = ea;
        r.eirv = eirv; r.edrv = edrv; r.erdata = erd;
        return r;
    endfunction

    task automatic drive(logic ir, logic [15:0] ia, logic dr, logic dw,
                         logic [15:0] da, logic [15:0] dd);
        bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    endtask

    vec_t tbl [17];

    // Reference model state for the random phase
    logic [15:0] ref_mem [256];
    int          waited;
    logic        pend_i, pend_d;
    logic [15:0] pend_data;
    logic        ri, rd, rwe;
    logic [15:0] ria, rda, rdw;
    logic        exp_ig, exp_dg;

    initial begin
        // ireq iaddr dreq dwe daddr dwdata | eig edg ewen eaddr eirv edrv erdata
        tbl[0]  = v(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[1]  = v(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0001, 1, 0, 16'h1000);
        tbl[2]  = v(1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 16'h1001);
        tbl[3]  = v(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h1002);
        tbl[4]  = v(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
        tbl[5]  = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 0, 0, 16'h0000);
        tbl[6]  = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 0, 1, 16'h1008);
        tbl[7]  = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 0, 1, 16'h1008);
        tbl[8]  = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 1, 0, 0, 16'h0005, 0, 1, 16'h1008);
        tbl[9]  = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 1, 0, 16'h1005);
        tbl[10] = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 0, 1, 16'h1008);
        tbl[11] = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 0, 1, 16'h1008);
        tbl[12] = v(1, 16'h0005, 1, 0, 16'h0008, 16'h0000, 1, 0, 0, 16'h0005, 0, 1, 16'h1008);
        tbl[13] = v(0, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 1, 1, 16'h0040, 1, 0, 16'h1005);
        tbl[14] = v(0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0040, 0, 0, 16'h0000);
        tbl[15] = v(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'hBEEF);
        tbl[16] = v(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);

        // Reset with requests active: everything must stay low.
        rst = 1'b1;
        preload = 1'b1;
        drive(1, 16'h0011, 1, 1, 16'h0022, 16'h3333);
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        #1;
        chk("rst_i_gnt", 32'(bus.i_gnt), 0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 0);
        chk("rst_i_rvalid", 32'(bus.i_rvalid), 0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);

        // Directed vector table; first row runs in the first cycle out of reset.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            drive(tbl[k].ireq, tbl[k].iaddr, tbl[k].dreq, tbl[k].dwe,
                  tbl[k].daddr, tbl[k].dwdata);
            #1;
            chk($sformatf("vec%0d_i_gnt", k), 32'(bus.i_gnt), 32'(tbl[k].eig));
            chk($sformatf("vec%0d_d_gnt", k), 32'(bus.d_gnt), 32'(tbl[k].edg));
            chk($sformatf("vec%0d_mem_wen", k), 32'(bus.mem_wen), 32'(tbl[k].ewen));
            chk($sformatf("vec%0d_mem_addr", k), 32'(bus.mem_addr), 32'(tbl[k].eaddr));
            chk($sformatf("vec%0d_mem_wdata", k), 32'(bus.mem_wdata),
                tbl[k].edg ? 32'(tbl[k].dwdata) : 32'd0);
            chk($sformatf("vec%0d_i_rvalid", k), 32'(bus.i_rvalid), 32'(tbl[k].eirv));
            chk($sformatf("vec%0d_d_rvalid", k), 32'(bus.d_rvalid), 32'(tbl[k].edrv));
            if (tbl[k].eirv)
                chk($sformatf("vec%0d_i_rdata", k), 32'(bus.i_rdata), 32'(tbl[k].erdata));
            if (tbl[k].edrv)
                chk($sformatf("vec%0d_d_rdata", k), 32'(bus.d_rdata), 32'(tbl[k].erdata));
        end

        // Reset asserted right after a fetch grant edge.
        @(negedge clk);
        drive(1, 16'h0003, 0, 0, 16'h0000, 16'h0000);
        #1;
        chk("mid_i_gnt", 32'(bus.i_gnt), 1);
        @(posedge clk);
        #1;
        chk("mid_pre_rvalid", 32'(bus.i_rvalid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid_drop", 32'(bus.i_rvalid), 0);
        chk("mid_i_gnt_rst", 32'(bus.i_gnt), 0);
        drive(0, 16'h0000, 1, 1, 16'h0041, 16'hDEAD);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("mid_wen_in_rst", 32'(bus.mem_wen), 0);
            chk("mid_d_gnt_in_rst", 32'(bus.d_gnt), 0);
            chk("mid_addr_in_rst", 32'(bus.mem_addr), 0);
        end
        chk("mid_mem_intact", 32'(mem[8'h41]), 32'h1041);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 16'h0007, 1, 0, 16'h0009, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk($sformatf("post_rst_i_gnt%0d", k), 32'(bus.i_gnt), (k % 4 == 3) ? 32'd1 : 32'd0);
            chk($sformatf("post_rst_d_gnt%0d", k), 32'(bus.d_gnt), (k % 4 == 3) ? 32'd0 : 32'd1);
        end

        // Random traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        preload = 1'b1;
        drive(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = 16'h1000 + 16'(a);
        waited = 0; pend_i = 1'b0; pend_d = 1'b0; pend_data = '0;
        ri = 1'b0; rd = 1'b0; rwe = 1'b0; ria = '0; rda = '0; rdw = '0;
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            drive(ri, ria, rd, rwe, rda, rdw);
            #1;
            // Fetch wins when alone, or after it has lost STARVE_MAX cycles in a row.
            exp_ig = ri && (!rd || waited >= 3);
            exp_dg = rd && !exp_ig;
            chk("rnd_i_gnt", 32'(bus.i_gnt), 32'(exp_ig));
            chk("rnd_d_gnt", 32'(bus.d_gnt), 32'(exp_dg));
            chk("rnd_mem_wen", 32'(bus.mem_wen), 32'(exp_dg && rwe));
            chk("rnd_mem_addr", 32'(bus.mem_addr), exp_ig ? 32'(ria) : exp_dg ? 32'(rda) : 32'd0);
            chk("rnd_mem_wdata", 32'(bus.mem_wdata), exp_dg ? 32'(rdw) : 32'd0);
            chk("rnd_i_rvalid", 32'(bus.i_rvalid), 32'(pend_i));
            chk("rnd_d_rvalid", 32'(bus.d_rvalid), 32'(pend_d));
            if (pend_i) chk("rnd_i_rdata", 32'(bus.i_rdata), 32'(pend_data));
            if (pend_d) chk("rnd_d_rdata", 32'(bus.d_rdata), 32'(pend_data));

            pend_i    = exp_ig;
            pend_d    = exp_dg && !rwe;
            pend_data = exp_ig ? ref_mem[ria[7:0]] : ref_mem[rda[7:0]];
            if (exp_dg && rwe) ref_mem[rda[7:0]] = rdw;
            waited    = (ri && !exp_ig) ? waited + 1 : 0;

            if ((ri && exp_ig) || !ri || ($urandom_range(0, 99) < 5)) begin
                ri  = ($urandom_range(0, 99) < 60);
                ria = 16'($urandom_range(0, 255));
            end
            if ((rd && exp_dg) || !rd || ($urandom_range(0, 99) < 5)) begin
                rd  = ($urandom_range(0, 99) < 60);
                rwe = ($urandom_range(0, 2) == 0);
                rda = 16'($urandom_range(0, 31));
                rdw = 16'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port `memory` instance between the instruction-fetch stage and the load/store stage. It sits between the pipeline and the memory's `addr`/`wen`/`data_in`/`data_out` pins. It grants at most one access per cycle, with data priority bounded by a starvation counter. It returns read data, tagged to the owning requester, one cycle after the grant, matching the memory's registered-address read.

## Interface
- `AW`, default `` `ISIZE ``: address width.
- `DW`, default `` `DSIZE ``: data width.
- `STARVE_MAX`, default 3: consecutive denied cycles after which a waiting fetch beats data; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch read request.
- `i_addr`  in  AW  fetch address.
- `i_gnt`  out  1  fetch granted this cycle (combinational).
- `i_rvalid`  out  1  `i_rdata` valid (registered).
- `i_rdata`  out  DW  fetch read data.
- `d_req`  in  1  load/store request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  load/store address.
- `d_wdata`  in  DW  store data.
- `d_gnt`  out  1  load/store granted this cycle (combinational).
- `d_rvalid`  out  1  `d_rdata` valid for loads only (registered).
- `d_rdata`  out  DW  load read data.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_wen`  out  1  to memory `wen`.
- `mem_wdata`  out  DW  to memory `data_in`.
- `mem_rdata`  in  DW  from memory `data_out`.

## Operation
- Arbitration is decided combinationally each cycle from `i_req`, `d_req` and `starve_cnt`. The state is `starve_cnt` (4 bits) plus `owner` (2 bits: NONE, I, D).
  - Only one requester active: it is granted.
  - Both active and `starve_cnt < STARVE_MAX`: D is granted and `starve_cnt` increments.
  - Both active and `starve_cnt == STARVE_MAX`: I is granted.
  - `starve_cnt` clears whenever I is granted or `i_req` is low.
  - `starve_cnt` saturates at `STARVE_MAX` and never wraps.
- Memory drive:
  - Grant I: `mem_addr = i_addr`, `mem_wen = 0`.
  - Grant D: `mem_addr = d_addr`, `mem_wen = d_we`, `mem_wdata = d_wdata`.
  - No grant: `mem_addr = 0`, `mem_wen = 0`, `mem_wdata = 0`.
- `mem_wen` is forced to 0 whenever `rst` is high, so the memory file load is never corrupted.
- Read return:
  - At each edge, `owner` is set to I (fetch grant), D (load grant), or NONE (store grant or idle).
  - The next cycle, `i_rvalid = (owner == I)` and `d_rvalid = (owner == D)`.
  - `i_rdata` and `d_rdata` both carry `mem_rdata` unmasked; consumers qualify them with their rvalid.
- Requesters hold req and operands stable until their gnt is seen. Deasserting without a grant is legal and drops the request.
- A store followed next cycle by a load to the same address returns the new data.

## Timing
- Grant-to-data latency is 1 cycle: request granted in cycle N gives rvalid and data in cycle N+1.
- Back-to-back grants are allowed every cycle, for full throughput.
- A store is complete at the edge ending its grant cycle; there is no response pulse.
- Reset values: `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `mem_wen` = 0; `mem_addr`, `mem_wdata` = 0; `owner` = NONE; `starve_cnt` = 0. The gnt and memory outputs stay 0 while `rst` is high, regardless of requests.
- Reset asserted mid-operation: a read granted in the previous cycle is discarded (rvalid 0) and the counter clears immediately (asynchronous).
- First grant is possible in the first cycle with `rst` low.

## Test plan
- Fetch only: `i_req=1` with `i_addr` 0, 1, 2 on consecutive cycles, memory preloaded 0x1000+addr → `i_gnt=1` every cycle; `i_rvalid=1` one cycle later with `i_rdata` 0x1000, 0x1001, 0x1002.
- Contention, `STARVE_MAX=3`: `i_req` and `d_req` (loads) held high → grant pattern D, D, D, I repeating; `d_rvalid` and `i_rvalid` follow the same pattern one cycle later.
- Store then load: store 0xBEEF to 0x0040, then load 0x0040 next cycle → `mem_wen=1` for exactly one cycle; no rvalid for the store; `d_rdata=0xBEEF` with `d_rvalid` two cycles after the store grant.
- Idle bus: both requests low → `mem_wen=0`, `mem_addr=0`, both rvalids 0, `starve_cnt` stays 0.
- Reset mid-read: assert `rst` asynchronously right after a fetch grant edge → `i_rvalid` drops to 0 immediately; `mem_wen=0` throughout reset even with `d_req=1, d_we=1`; after release, arbitration restarts with `starve_cnt=0`.
